serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per cycle,
// LSB first, with a final borrow flag that is set when a < b.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_r;
    logic             d;
    logic             br_next;

    // Full-subtractor cell operating on the current LSBs and the running borrow
    assign d       = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The result register is not cleared on accept; the shifts overwrite it fully
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= {d, res[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) bout_r <= br_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign diff = res;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8), compared against
// plain-arithmetic expectations of (a - b) mod 256 and a < b.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int unsigned r;
        r = (int'(x) - int'(y) + 256) % 256;
        return WIDTH'(r);
    endfunction

    function automatic logic ref_bout(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return (int'(x) < int'(y));
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or on timeout)
    task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         output int latency, output int busy_cycles, output bit timed_out);
        start = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        latency = 0;
        busy_cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            latency++;
            if (busy) busy_cycles++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #3;
        checks++;
        if ({busy, done, diff, bout} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b, want all zero", busy, done, diff, bout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        bit to;
        do_op(8'd5, 8'd3, lat, bc, to);
        checks++;
        if (to || lat != 9) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d (timeout=%0b), want 9", lat, to);
        end
        checks++;
        if (diff !== 8'h02 || bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_result: got diff=%h bout=%b, want 02 0", diff, bout);
        end
        checks++;
        if (bc != 9) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles: got %0d, want 9", bc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_single_pulse: got done=%b busy=%b, want 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (diff !== 8'h02 || bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_hold: got diff=%h bout=%b, want 02 0", diff, bout);
        end
    endtask

    task automatic test_corners();
        logic [WIDTH-1:0] ca [4] = '{8'h00, 8'h80, 8'hFF, 8'h00};
        logic [WIDTH-1:0] cb [4] = '{8'h01, 8'h7F, 8'hFF, 8'hFF};
        logic [WIDTH-1:0] ed [4] = '{8'hFF, 8'h01, 8'h00, 8'h01};
        logic             eb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat, bc;
        bit to;
        for (int i = 0; i < 4; i++) begin
            do_op(ca[i], cb[i], lat, bc, to);
            checks++;
            if (to || diff !== ed[i] || bout !== eb[i]) begin
                errors++;
                $display("[TB] FAIL corner_%0d: %h-%h got diff=%h bout=%b timeout=%0b, want %h %b",
                         i, ca[i], cb[i], diff, bout, to, ed[i], eb[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int done_count = 0;
        int first_done = -1;
        int second_done = -1;
        start = 1'b1;
        a = 8'd5;
        b = 8'd3;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_count++;
                if (first_done < 0) begin
                    first_done = cyc;
                    checks++;
                    if (diff !== 8'h02) begin
                        errors++;
                        $display("[TB] FAIL b2b_first_diff: got %h, want 02", diff);
                    end
                end else if (second_done < 0) begin
                    second_done = cyc;
                    checks++;
                    if (diff !== 8'h08 || bout !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL b2b_second_result: got diff=%h bout=%b, want 08 0", diff, bout);
                    end
                end
            end
            // Re-pulse 9-1 during RUN (cycle 3), in DONE, and the first IDLE cycle after
            if (cyc == 3 || (first_done > 0 && (cyc == first_done || cyc == first_done + 1))) begin
                start = 1'b1;
                a = 8'd9;
                b = 8'd1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (done_count != 2 || second_done - first_done != 10) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d dones at %0d/%0d, want 2 dones 10 apart",
                     done_count, first_done, second_done);
        end
    endtask

    task automatic test_reset_abort();
        int spurious = 0;
        int lat, bc;
        bit to;
        start = 1'b1;
        a = 8'd5;
        b = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, bout} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_async_clear: got busy=%b done=%b diff=%h bout=%b, want all zero",
                     busy, done, diff, bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d done pulses, want 0", spurious);
        end
        do_op(8'd7, 8'd2, lat, bc, to);
        checks++;
        if (to || diff !== 8'h05 || bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_recover: got diff=%h bout=%b timeout=%0b, want 05 0", diff, bout, to);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb;
        int lat, bc;
        bit to;
        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            do_op(ra, rb, lat, bc, to);
            checks++;
            if (to || lat != 9 || diff !== ref_diff(ra, rb) || bout !== ref_bout(ra, rb)) begin
                errors++;
                $display("[TB] FAIL random_%0d: %h-%h got diff=%h bout=%b lat=%0d, want %h %b lat=9",
                         n, ra, rb, diff, bout, lat, ref_diff(ra, rb), ref_bout(ra, rb));
            end
            @(negedge clk);
            repeat ($urandom_range(0, 3)) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
